dreg_share_arbiter: RTL

Round-robin write arbiter for a shared D-flip-flop data register. Up to NREQ requesters each present a data word and a request; the block grants one requester at a time, loads that requester's word into a WIDTH-bit register with true and complementary outputs, and returns a one-cycle acknowledge. It sits between requesting agents and the shared storage register and sequences every write to it.

---
 rtl/dreg_share_arbiter_if.sv | 14 +
 rtl/dreg_share_arbiter.sv | 72 +++++++
 2 files changed

// File: rtl/dreg_share_arbiter_if.sv
// dreg_share_arbiter_if: requester-side bundle for the shared data register arbiter.
interface dreg_share_arbiter_if #(parameter int IDXW = 2, parameter int WIDTH = 8);
  localparam int NREQ = 2 ** IDXW;
  logic [NREQ-1:0] req;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] ack;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_bar;
  logic [IDXW-1:0] owner;
  logic busy;
  modport master (output req, wdata, input gnt, ack, q, q_bar, owner, busy);
  modport slave (input req, wdata, output gnt, ack, q, q_bar, owner, busy);
endinterface

// File: rtl/dreg_share_arbiter.sv
// dreg_share_arbiter: round-robin write arbiter for a shared WIDTH-bit register with true/complement outputs.
// Define DREG_ARB_FIXED_PRIO_EN to select the lowest-index requester instead of round-robin.
module dreg_share_arbiter #(
  parameter int IDXW = 2,
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic reset,
  dreg_share_arbiter_if.slave bus
);
  localparam int NREQ = 2 ** IDXW;
  typedef enum logic [1:0] {IDLE, GRANT, ACK} state_t;
  state_t state;
  logic [IDXW-1:0] ptr, win, sel;
  logic [NREQ-1:0] gnt, ack;
  logic [WIDTH-1:0] q;
  logic [IDXW-1:0] owner;
  logic busy;
  always_comb begin
    sel = '0;
`ifdef DREG_ARB_FIXED_PRIO_EN
    for (int i = NREQ - 1; i >= 0; i--) if (bus.req[i]) sel = IDXW'(i);
`else
    // nearest set bit after ptr wins; offset NREQ wraps back to ptr itself
    for (int i = NREQ; i >= 1; i--) if (bus.req[ptr + IDXW'(i)]) sel = ptr + IDXW'(i);
`endif
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      gnt <= '0;
      ack <= '0;
      q <= '0;
      owner <= '0;
      busy <= 1'b0;
      ptr <= '1;
      win <= '0;
    end else
      case (state)
        IDLE: if (|bus.req) begin
          win <= sel;
          gnt <= NREQ'(1) << sel;
          busy <= 1'b1;
          state <= GRANT;
        end
        GRANT: begin
          gnt <= '0;
          if (bus.req[win]) begin
            q <= bus.wdata[win*WIDTH +: WIDTH];
            ack <= NREQ'(1) << win;
            owner <= win;
            ptr <= win;
            state <= ACK;
          end else begin
            busy <= 1'b0;
            state <= IDLE;
          end
        end
        ACK: begin
          ack <= '0;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
  assign bus.gnt = gnt;
  assign bus.ack = ack;
  assign bus.q = q;
  assign bus.q_bar = ~q;
  assign bus.owner = owner;
  assign bus.busy = busy;
endmodule
